result_serializer: RTL and testbench

RESULT_SERIALIZER -- requirements
Module: result_serializer

---
 rtl/result_serializer_if.sv | 32 +++
 rtl/result_serializer.sv | 96 +++++++++
 tb/tb_result_serializer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/result_serializer_if.sv
// Handshake bundle between the result producer, the serializer and the UART transmitter.
interface result_serializer_if #(
  parameter int unsigned WIDTH_DIN = 128
);
  logic [WIDTH_DIN-1:0] din;
  logic                 din_valid;
  logic                 busy;
  logic                 overflow;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output din,
    output din_valid,
    output tx_ready,
    input  busy,
    input  overflow,
    input  tx_data,
    input  tx_valid
  );

  modport slave (
    input  din,
    input  din_valid,
    input  tx_ready,
    output busy,
    output overflow,
    output tx_data,
    output tx_valid
  );
endinterface

// File: rtl/result_serializer.sv
// Serializes a WIDTH_DIN-bit result word into MSB-first bytes for a UART transmitter.
// Define RESULT_SERIALIZER_HEADER_EN to prefix each frame with the sync byte 0xA5.
module result_serializer #(
  parameter int unsigned WIDTH_DIN = 128
) (
  input  logic               clk,
  input  logic               rst,
  result_serializer_if.slave bus
);

  localparam int unsigned NBYTES = WIDTH_DIN / 8;
  localparam int unsigned CntW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NBYTES - 1);
`ifdef RESULT_SERIALIZER_HEADER_EN
  localparam logic [7:0] SyncByte = 8'hA5;
`endif

  typedef enum logic [1:0] {
    StIdle = 2'd0,
`ifdef RESULT_SERIALIZER_HEADER_EN
    StHdr  = 2'd1,
`endif
    StData = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH_DIN-1:0] shift_q, shift_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 tx_valid;
  logic                 xfer;

  assign tx_valid = (state_q != StIdle);
  assign xfer     = tx_valid && bus.tx_ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    // Any strobe that arrives while a frame is in flight is dropped and remembered.
    ovf_d   = ovf_q | (bus.din_valid && (state_q != StIdle));
    unique case (state_q)
      StIdle: begin
        if (bus.din_valid) begin
          shift_d = bus.din;
          cnt_d   = '0;
`ifdef RESULT_SERIALIZER_HEADER_EN
          state_d = StHdr;
`else
          state_d = StData;
`endif
        end
      end
`ifdef RESULT_SERIALIZER_HEADER_EN
      StHdr: begin
        if (xfer) state_d = StData;
      end
`endif
      StData: begin
        if (xfer) begin
          shift_d = shift_q << 8;
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    bus.tx_data = 8'h00;
    if (state_q == StData) bus.tx_data = shift_q[WIDTH_DIN-1 -: 8];
`ifdef RESULT_SERIALIZER_HEADER_EN
    if (state_q == StHdr) bus.tx_data = SyncByte;
`endif
  end

  assign bus.tx_valid = tx_valid;
  assign bus.busy     = tx_valid;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench for result_serializer: byte scoreboard plus table-driven frames and
// hand-written overflow, reset and back-to-back sequences.
module tb_result_serializer;

  localparam int unsigned W  = 128;
  localparam int unsigned NB = W / 8;
`ifdef RESULT_SERIALIZER_HEADER_EN
  localparam int unsigned FB = NB + 1;
`else
  localparam int unsigned FB = NB;
`endif

  logic clk = 1'b0;
  logic rst;

  result_serializer_if #(.WIDTH_DIN(W)) bus ();

  result_serializer #(.WIDTH_DIN(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] din;
    int unsigned  period;      // tx_ready high one cycle in every `period`
    int unsigned  exp_cycles;  // cycles from first valid byte until busy falls
  } vec_t;

  vec_t        vecs[5];
  logic [7:0]  q[$];
  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  int unsigned xfers  = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] d);
`ifdef RESULT_SERIALIZER_HEADER_EN
    q.push_back(8'hA5);
`endif
    for (int k = 0; k < NB; k++) q.push_back(d[W-1-8*k -: 8]);
  endtask

  // One clock: scoreboard the byte on offer at the negedge, then step past the posedge.
  task automatic cycle();
    @(negedge clk);
    if (!rst && bus.tx_valid) begin
      if (q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", bus.tx_data);
      end else begin
        check("tx_data", bus.tx_data, q[0]);
        if (bus.tx_ready) begin
          void'(q.pop_front());
          xfers++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [W-1:0] d);
    push_frame(d);
    bus.din       = d;
    bus.din_valid = 1'b1;
    cycle();
    bus.din_valid = 1'b0;
  endtask

  task automatic drain(input int unsigned period, output int unsigned cycles);
    cycles = 0;
    while (bus.busy && cycles < 1000) begin
      bus.tx_ready = ((cycles % period) == 0);
      cycle();
      cycles++;
    end
    if (bus.busy) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: got busy=1 after %0d cycles, expected busy=0", cycles);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int unsigned x0;
    int unsigned c;
    strobe(v.din);
    check("tx_valid_latency", bus.tx_valid, 1);
    x0 = xfers;
    drain(v.period, c);
    check("frame_bytes", xfers - x0, FB);
    check("frame_cycles", c, v.exp_cycles);
    check("busy_after", bus.busy, 0);
    check("tx_valid_after", bus.tx_valid, 0);
    check("queue_empty", q.size(), 0);
  endtask

  initial begin
    int unsigned x0;
    int unsigned c1;
    int unsigned c2;
    int unsigned n;

    vecs[0] = '{din: 128'h000102030405060708090A0B0C0D0E0F, period: 1, exp_cycles: FB};
    vecs[1] = '{din: {{(W-8){1'b1}}, 8'hBC}, period: 3, exp_cycles: 3*FB-2};
    vecs[2] = '{din: 128'h0123456789ABCDEFFEDCBA9876543210, period: 2, exp_cycles: 2*FB-1};
    vecs[3] = '{din: 128'd50, period: 1, exp_cycles: FB};
    vecs[4] = '{din: {W{1'b1}}, period: 1, exp_cycles: FB};

    rst           = 1'b1;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.tx_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_tx_valid", bus.tx_valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_overflow", bus.overflow, 0);
    check("reset_tx_data", bus.tx_data, 0);
    rst = 1'b0;

    // Table-driven frames; the first strobe lands on the first edge with rst low.
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i]);
      check("overflow_clear", bus.overflow, 0);
      bus.tx_ready = 1'b0;
      cycle();
    end

    // Back-to-back: second strobe in the first idle cycle.
    x0 = xfers;
    strobe(vecs[0].din);
    drain(1, c1);
    strobe(vecs[2].din);
    drain(1, c2);
    check("b2b_cycles", c1 + 1 + c2, 2*FB + 1);
    check("b2b_bytes", xfers - x0, 2*FB);
    check("b2b_overflow", bus.overflow, 0);
    check("b2b_queue_empty", q.size(), 0);

    // Overflow: a second word 5 cycles into the frame is dropped.
    x0 = xfers;
    strobe(vecs[0].din);
    n = 0;
    while (bus.busy && n < 1000) begin
      bus.tx_ready  = 1'b1;
      bus.din_valid = (n == 5);
      bus.din       = vecs[4].din;
      cycle();
      n++;
    end
    bus.din_valid = 1'b0;
    check("ovf_frame_bytes", xfers - x0, FB);
    check("ovf_frame_cycles", n, FB);
    check("ovf_flag", bus.overflow, 1);
    repeat (4) cycle();
    check("ovf_queue_empty", q.size(), 0);
    run_frame(vecs[2]);
    check("ovf_sticky", bus.overflow, 1);

    // Reset after 7 bytes: outputs clear at once, new frame starts from byte 0.
    x0 = xfers;
    strobe(vecs[0].din);
    bus.tx_ready = 1'b1;
    repeat (7) cycle();
    check("pre_reset_bytes", xfers - x0, 7);
    rst = 1'b1;
    #1;
    check("midrst_tx_valid", bus.tx_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_overflow", bus.overflow, 0);
    check("midrst_tx_data", bus.tx_data, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_frame(vecs[1]);

    // Strobe on the very cycle the last byte transfers is also an overflow.
    x0 = xfers;
    strobe(vecs[3].din);
    n = 0;
    while (bus.busy && n < 1000) begin
      bus.tx_ready  = 1'b1;
      bus.din_valid = (n == FB - 1);
      bus.din       = vecs[4].din;
      cycle();
      n++;
    end
    bus.din_valid = 1'b0;
    check("last_ovf_flag", bus.overflow, 1);
    check("last_ovf_busy", bus.busy, 0);
    repeat (3) cycle();
    check("last_ovf_bytes", xfers - x0, FB);
    check("last_ovf_queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
